// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan arbiter.
// Channel count, channel index width and the arbiter state encoding.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2,
        ACK    = 2'd3
    } state_e;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: returns the first set request bit
// starting at ptr and wrapping modulo 4.
module rr_pick4
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              any,
    output logic [CH_W-1:0]   ch
);

    logic [CH_W-1:0] w_idx;

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        any   = 1'b0;
        ch    = '0;
        w_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = ptr + CH_W'(k);
            if (req[w_idx]) begin
                any = 1'b1;
                ch  = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux_scan_arbiter.sv
// Round-robin upstream controller for a 4:1 channel mux: selects a channel,
// waits out the mux settle time, samples mux_out and hands it downstream.
module mux_scan_arbiter
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] ack,
    output logic              address0,
    output logic              address1,
    input  logic              mux_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    output logic [CH_W-1:0]   out_channel
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(SETTLE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow to hold SETTLE_CYCLES");
    end

    state_e            r_state,       w_state_nxt;
    logic [CH_W-1:0]   r_ptr,         w_ptr_nxt;
    logic [CNT_W-1:0]  r_cnt,         w_cnt_nxt;
    logic [CH_W-1:0]   r_addr,        w_addr_nxt;
    logic [NUM_CH-1:0] r_ack,         w_ack_nxt;
    logic              r_out_valid,   w_valid_nxt;
    logic              r_out_data,    w_data_nxt;
    logic [CH_W-1:0]   r_out_channel, w_chan_nxt;

    logic              w_any;
    logic [CH_W-1:0]   w_pick;

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .ch  (w_pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_ack         <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= 1'b0;
            r_out_channel <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_addr        <= w_addr_nxt;
            r_ack         <= w_ack_nxt;
            r_out_valid   <= w_valid_nxt;
            r_out_data    <= w_data_nxt;
            r_out_channel <= w_chan_nxt;
        end
    end

    // Address only changes on a grant, so an idle mux never sees a select glitch.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_ack_nxt   = '0;
        w_valid_nxt = r_out_valid;
        w_data_nxt  = r_out_data;
        w_chan_nxt  = r_out_channel;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_addr_nxt  = w_pick;
                    w_chan_nxt  = w_pick;
                    w_cnt_nxt   = CNT_W'(SETTLE_CYCLES);
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt > CNT_W'(1)) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                    w_data_nxt  = mux_out;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_ack_nxt   = onehot(r_out_channel);
                    w_ptr_nxt   = r_out_channel + CH_W'(1);
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ack         = r_ack;
    assign address0    = r_addr[0];
    assign address1    = r_addr[1];
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_channel = r_out_channel;

endmodule
